pc_fetch_sequencer: RTL
=======================

// Module: pc_fetch_sequencer
// PURPOSE
//   Owns the program counter and sequences instruction fetch for the RISC-V datapath.
//   Issues req/ack reads to instruction memory and presents one instruction at a time to decode.
//   Computes the PC+4 link/fall-through value and applies branch/jump redirects.
//   Sits between instruction memory and decode; replaces the free-running PC register + adder pair.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//   PC_STEP       4              sequential increment in bytes
// PORTS
//   clk              in   1   single clock, rising edge
//   reset            in   1   asynchronous, active-high reset
//   imem_req         out  1   fetch request, held until imem_ack
//   imem_addr        out  32  fetch address, stable while imem_req=1
//   imem_ack         in   1   memory completes request this cycle; imem_rdata valid
//   imem_rdata       in   32  fetched instruction word
//   inst_valid       out  1   inst_out/inst_pc valid for decode
//   inst_ready       in   1   decode accepts instruction (handshake = valid & ready)
//   inst_out         out  32  instruction word
//   inst_pc          out  32  address of inst_out
//   inst_pc4         out  32  inst_pc + PC_STEP, combinational, mod 2^32
//   redirect_valid   in   1   branch/jump taken this cycle (pulse)
//   redirect_target  in   32  new PC
//   misalign_err     out  1   only with PC_MISALIGN_TRAP_EN; else tied 0
// BEHAVIOUR
//   Reset (async): pc=RESET_VECTOR, state=IDLE; imem_req=0, imem_addr=RESET_VECTOR,
//     inst_valid=0, inst_out=0, inst_pc=0, misalign_err=0.
//     Reset mid-transaction abandons it; memory is reset in the same domain.
//   States: IDLE, FETCH, ISSUE, DRAIN (+ ERROR with macro).
//   IDLE: next cycle -> FETCH.
//   FETCH: imem_req=1, imem_addr=pc.
//     On ack: inst_out<=rdata, inst_pc<=pc, pc<=pc+PC_STEP, inst_valid<=1 -> ISSUE.
//   ISSUE: imem_req=0; outputs held stable until valid&ready.
//     On handshake: inst_valid<=0 -> FETCH.
//   Latency: 0-wait memory gives inst_valid 1 cycle after req.
//     Peak throughput: one instruction per 2 cycles.
//   Redirect (highest priority, any state):
//     IDLE: pc<=target -> FETCH.
//     ISSUE: inst_valid<=0, pc<=target -> FETCH.
//       Simultaneous inst_ready: instruction counts as consumed.
//     FETCH with ack same cycle: rdata discarded, pc<=target -> FETCH.
//     FETCH without ack: pc<=target -> DRAIN.
//   DRAIN: imem_req/imem_addr held (old address) until ack.
//     Data discarded, inst_valid stays 0 -> FETCH.
//     Further redirects in DRAIN overwrite pc (last wins).
//   Arithmetic: pc and inst_pc4 wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
//   imem_req never deasserts before ack; no new request in the ack cycle.
// CONFIGURATION
//   PC_MISALIGN_TRAP_EN defined:
//     redirect_target[1:0]!=0 -> state ERROR, misalign_err=1, imem_req=0, inst_valid=0.
//     ERROR is held until reset.
//     Misaligned redirect during DRAIN: still wait for ack, then enter ERROR.
//   Not defined:
//     target[1:0] forced to 2'b00; misalign_err tied 0; no ERROR state.
// TESTING
//   1 reset, 0-wait mem, ready=1: req at addr 0,4,8 -> inst_valid every 2nd cycle;
//     inst_pc 0,4,8; inst_pc4 4,8,12.
//   2 ack delayed 3 cycles: imem_addr stable, req high for 4 cycles, no inst_valid until after ack.
//   3 ISSUE with inst_ready=0 for 5 cycles: inst_out/inst_pc unchanged, no new req.
//   4 redirect to 0x100 in FETCH, ack 2 cycles later:
//     DRAIN, old data dropped, next req addr 0x100.
//   5 redirect to 0x40 with inst_ready same cycle in ISSUE:
//     inst_valid drops, next req 0x40.
//   6 pc=0xFFFF_FFFC fetched: inst_pc4=0, next req 0.
//     With PC_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_err=1, req stays 0.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer: req/ack fetch from imem, one instruction at a time to decode.
// Optional PC_MISALIGN_TRAP_EN macro adds a sticky ERROR state on misaligned redirect targets.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misalign_err
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DRAIN} state_t;
`endif

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr;
    logic [31:0] target;
    logic        load_inst, clr_valid, drain_ld;

`ifdef PC_MISALIGN_TRAP_EN
    logic err_pend, err_pend_nxt;
    logic bad_target;
    assign target     = redirect_target;
    assign bad_target = redirect_target[1:0] != 2'b00;
`else
    assign target = {redirect_target[31:2], 2'b00};
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load_inst = 1'b0;
        clr_valid = 1'b0;
        drain_ld  = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        err_pend_nxt = err_pend;
`endif
        case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect_valid) pc_nxt = target;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_nxt = target;
                    if (imem_ack) begin
                        state_nxt = FETCH;
                    end else begin
                        // request is still outstanding: wait it out at the old address
                        state_nxt = DRAIN;
                        drain_ld  = 1'b1;
                    end
                end else if (imem_ack) begin
                    load_inst = 1'b1;
                    pc_nxt    = pc + STEP;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect_valid) begin
                    clr_valid = 1'b1;
                    pc_nxt    = target;
                    state_nxt = FETCH;
                end else if (inst_ready) begin
                    clr_valid = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_valid) pc_nxt = target;
                if (imem_ack) state_nxt = FETCH;
            end
            default: state_nxt = state;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        // a misaligned target traps at once unless a request must first be drained
        if (redirect_valid && bad_target && state != ERROR) begin
            if (state_nxt == DRAIN) begin
                err_pend_nxt = 1'b1;
            end else begin
                state_nxt = ERROR;
                clr_valid = 1'b1;
            end
        end
        if (state == DRAIN && imem_ack && err_pend) state_nxt = ERROR;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            drain_addr <= RESET_VECTOR;
            inst_valid <= 1'b0;
            inst_out   <= 32'h0;
            inst_pc    <= 32'h0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (drain_ld) drain_addr <= pc;
            if (load_inst) begin
                inst_out   <= imem_rdata;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
            end else if (clr_valid) begin
                inst_valid <= 1'b0;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_pend <= 1'b0;
        else       err_pend <= err_pend_nxt;
    end
    assign misalign_err = state == ERROR;
`else
    assign misalign_err = 1'b0;
`endif

    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign inst_pc4  = inst_pc + STEP;

endmodule
